// File: rtl/key_input_conditioner_if.sv
// key_input_conditioner_if
//   Groups the raw board inputs and the conditioned outputs of
//   key_input_conditioner.
//   slave  : the conditioner (reads the raw inputs, drives the outputs).
//   master : the board/remap side (drives the raw inputs, reads the outputs).
//   raw_keys   [6:0] raw note keys, bit 6 = key1 ... bit 0 = key7
//   raw_pick         raw pick button, active high
//   key_onehot [6:0] winning key, one-hot, raw_keys bit order
//   key_valid        any debounced key pressed
//   multi_key        two or more debounced keys pressed
//   note_code  [3:0] winning key number 1..7, 0 when none
//   pick_level       debounced pick level
//   pick_pulse       one-clk pulse on debounced pick rise
interface key_input_conditioner_if;
   logic [6:0] raw_keys;
   logic       raw_pick;
   logic [6:0] key_onehot;
   logic       key_valid;
   logic       multi_key;
   logic [3:0] note_code;
   logic       pick_level;
   logic       pick_pulse;

   modport master (
      output raw_keys, raw_pick,
      input  key_onehot, key_valid, multi_key, note_code, pick_level, pick_pulse
   );

   modport slave (
      input  raw_keys, raw_pick,
      output key_onehot, key_valid, multi_key, note_code, pick_level, pick_pulse
   );
endinterface

// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//   Front end for the key-remap stage: each of the 8 raw inputs
//   (7 note keys + pick) is synchronised through two flops and debounced
//   independently; the debounced keys are priority-encoded (key1 wins) and
//   the debounced pick yields a level plus a one-clk rising-edge pulse.
//   All outputs are registered.
//   clk : system clock
//   rst : asynchronous reset, active low
//   kin : key_input_conditioner_if.slave (raw inputs in, conditioned outputs)

// key_debounce
//   One input lane: 2-flop synchroniser followed by a stability counter.
//   deb follows the synchronised input only after it has differed from deb
//   for DEBOUNCE_CYCLES consecutive clocks; any reversion restarts the count.
//   clk, rst : as above
//   raw      : asynchronous raw input
//   deb      : debounced level
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic deb
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1, s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         deb <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == deb) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            // stable long enough: accept the new level and rearm
            deb <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

module key_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input logic                    clk,
   input logic                    rst,
   key_input_conditioner_if.slave kin
);
   localparam int NUM_LANES = 8;   // 7 keys + pick (bit 7)

   logic [NUM_LANES-1:0] raw_all;
   logic [NUM_LANES-1:0] deb_all;
   logic [6:0]           deb_keys;
   logic                 deb_pick;

   assign raw_all  = {kin.raw_pick, kin.raw_keys};
   assign deb_keys = deb_all[6:0];
   assign deb_pick = deb_all[7];

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_deb (
         .clk (clk),
         .rst (rst),
         .raw (raw_all[i]),
         .deb (deb_all[i])
      );
   end

   // Priority encode: scanning upward, the last hit is the highest bit,
   // i.e. key1 (bit 6) has top priority.
   logic [6:0] win_oh;
   logic [3:0] win_code;
   logic       many_keys;

   always_comb begin
      win_oh   = '0;
      win_code = '0;
      for (int k = 0; k < 7; k++) begin
         if (deb_keys[k]) begin
            win_oh   = 7'(1) << k;
            win_code = 4'(7 - k);
         end
      end
   end

   // clearing the lowest set bit leaves something iff popcount >= 2
   assign many_keys = |(deb_keys & (deb_keys - 7'd1));

   logic [6:0] onehot_q;
   logic       valid_q, multi_q, level_q, pulse_q;
   logic [3:0] code_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         onehot_q <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         multi_q  <= 1'b0;
         level_q  <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         onehot_q <= win_oh;
         code_q   <= win_code;
         valid_q  <= |deb_keys;
         multi_q  <= many_keys;
         level_q  <= deb_pick;
         // level_q still holds the previous deb_pick, so the pulse lines
         // up with the level rise
         pulse_q  <= deb_pick & ~level_q;
      end
   end

   assign kin.key_onehot = onehot_q;
   assign kin.note_code  = code_q;
   assign kin.key_valid  = valid_q;
   assign kin.multi_key  = multi_q;
   assign kin.pick_level = level_q;
   assign kin.pick_pulse = pulse_q;
endmodule

// File: tb/tb_key_input_conditioner.sv
module tb_key_input_conditioner;
   localparam int D  = 4;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   key_input_conditioner_if kin_if ();

   key_input_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kin (kin_if)
   );

   int total = 0;
   int bad   = 0;

   // Reference model. hist holds raw samples {pick, keys}, newest first.
   // An input's accepted level flips once the twice-delayed samples have
   // disagreed with it for D samples in a row.
   logic [7:0]  hist [$];
   logic [7:0]  m_deb, m_deb_q;
   logic [14:0] m_out;

   typedef struct {
      logic [6:0] keys;
      logic [6:0] oh;
      logic [3:0] code;
      logic       valid;
      logic       multi;
   } vec_t;
   vec_t tbl [8];

   function automatic logic [14:0] expect_out(input logic [7:0] d, input logic [7:0] dq);
      logic [6:0] oh   = '0;
      logic [3:0] code = '0;
      int         n    = 0;
      for (int k = 1; k <= 7; k++) begin
         if (d[7-k]) begin
            n++;
            if (code == 4'd0) begin
               code     = 4'(k);
               oh[7-k]  = 1'b1;
            end
         end
      end
      return {oh, n > 0, n >= 2, code, d[7], d[7] & ~dq[7]};
   endfunction

   function automatic logic [14:0] dut_out();
      return {kin_if.key_onehot, kin_if.key_valid, kin_if.multi_key,
              kin_if.note_code, kin_if.pick_level, kin_if.pick_pulse};
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i <= D; i++) hist.push_back(8'h00);
      m_deb   = '0;
      m_deb_q = '0;
      m_out   = '0;
   endtask

   task automatic check_model(input string nm);
      total++;
      if (dut_out() !== m_out) begin
         bad++;
         $display("FAIL %s: got %h want %h @%0t", nm, dut_out(), m_out, $time);
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
      end
   endtask

   // one clock: advance the model on the edge, compare 1 time unit later
   task automatic cycle();
      logic [7:0] r;
      logic       flip;
      @(posedge clk);
      r = {kin_if.raw_pick, kin_if.raw_keys};
      if (!rst) begin
         model_reset();
      end else begin
         m_out   = expect_out(m_deb, m_deb_q);
         m_deb_q = m_deb;
         for (int b = 0; b < 8; b++) begin
            flip = 1'b1;
            for (int k = 1; k <= D; k++)
               if (hist[k][b] == m_deb[b]) flip = 1'b0;
            if (flip) m_deb[b] = ~m_deb[b];
         end
         hist.push_front(r);
         void'(hist.pop_back());
      end
      #1;
      check_model("model");
   endtask

   task automatic assert_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check_model("rst_async");
   endtask

   int pulses, pulse_edge;

   initial begin
      tbl[0] = '{7'b0010000, 7'b0010000, 4'd3, 1'b1, 1'b0};
      tbl[1] = '{7'b0000001, 7'b0000001, 4'd7, 1'b1, 1'b0};
      tbl[2] = '{7'b1000001, 7'b1000000, 4'd1, 1'b1, 1'b1};
      tbl[3] = '{7'b0111000, 7'b0100000, 4'd2, 1'b1, 1'b1};
      tbl[4] = '{7'b0000110, 7'b0000100, 4'd5, 1'b1, 1'b1};
      tbl[5] = '{7'b1111111, 7'b1000000, 4'd1, 1'b1, 1'b1};
      tbl[6] = '{7'b0000000, 7'b0000000, 4'd0, 1'b0, 1'b0};
      tbl[7] = '{7'b0001000, 7'b0001000, 4'd4, 1'b1, 1'b0};

      kin_if.raw_keys = '0;
      kin_if.raw_pick = 1'b0;
      model_reset();
      #1;
      chk("reset_state", 16'(dut_out()), 16'd0);
      repeat (3) cycle();
      rst = 1'b1;

      // key3 latency: first sampled at edge 0, visible after edge D+2
      kin_if.raw_keys = 7'b0010000;
      for (int e = 0; e <= D + 1; e++) begin
         cycle();
         chk("lat_early", 16'(dut_out()), 16'd0);
      end
      cycle();
      chk("lat_oh",    16'(kin_if.key_onehot), 16'b0010000);
      chk("lat_code",  16'(kin_if.note_code),  16'd3);
      chk("lat_valid", 16'(kin_if.key_valid),  16'd1);
      chk("lat_multi", 16'(kin_if.multi_key),  16'd0);

      // encoder table
      for (int i = 0; i < 8; i++) begin
         kin_if.raw_keys = tbl[i].keys;
         repeat (D + 4) cycle();
         chk("tbl_oh",    16'(kin_if.key_onehot), 16'(tbl[i].oh));
         chk("tbl_code",  16'(kin_if.note_code),  16'(tbl[i].code));
         chk("tbl_valid", 16'(kin_if.key_valid),  16'(tbl[i].valid));
         chk("tbl_multi", 16'(kin_if.multi_key),  16'(tbl[i].multi));
      end

      // pick bounce then hold
      kin_if.raw_keys = '0;
      repeat (D + 4) cycle();
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         kin_if.raw_pick = (i % 2 == 0);
         cycle();
         if (kin_if.pick_pulse) pulses++;
      end
      kin_if.raw_pick = 1'b1;
      pulse_edge = -1;
      for (int e = 0; e < 20; e++) begin
         cycle();
         if (kin_if.pick_pulse) begin
            pulses++;
            pulse_edge = e;
         end
      end
      chk("bounce_pulses", 16'(pulses), 16'd1);
      chk("bounce_edge",   16'(pulse_edge), 16'(D + 2));
      chk("bounce_level",  16'(kin_if.pick_level), 16'd1);
      kin_if.raw_pick = 1'b0;
      pulses = 0;
      for (int e = 0; e < 15; e++) begin
         cycle();
         if (kin_if.pick_pulse) pulses++;
      end
      chk("release_pulses", 16'(pulses), 16'd0);
      chk("release_level",  16'(kin_if.pick_level), 16'd0);

      // multi-key: key5, add key2, release key2
      kin_if.raw_keys = 7'b0000100;
      repeat (D + 4) cycle();
      chk("mk_code5", 16'(kin_if.note_code), 16'd5);
      kin_if.raw_keys = 7'b0100100;
      repeat (D + 4) cycle();
      chk("mk_code2", 16'(kin_if.note_code),  16'd2);
      chk("mk_oh2",   16'(kin_if.key_onehot), 16'b0100000);
      chk("mk_multi", 16'(kin_if.multi_key),  16'd1);
      kin_if.raw_keys = 7'b0000100;
      repeat (D + 4) cycle();
      chk("mk_back5",  16'(kin_if.note_code), 16'd5);
      chk("mk_single", 16'(kin_if.multi_key), 16'd0);

      // glitch on key7 shorter than the debounce window
      kin_if.raw_keys = '0;
      repeat (D + 4) cycle();
      kin_if.raw_keys = 7'b0000001;
      repeat (D - 1) cycle();
      kin_if.raw_keys = '0;
      for (int e = 0; e < D + 6; e++) begin
         cycle();
         chk("glitch_valid", 16'(kin_if.key_valid), 16'd0);
         chk("glitch_code",  16'(kin_if.note_code), 16'd0);
      end

      // reset mid-debounce, key1 still held across release
      kin_if.raw_keys = 7'b0000100;
      repeat (D + 4) cycle();
      kin_if.raw_keys = 7'b1000100;
      repeat (4) cycle();
      chk("mid_code_pre", 16'(kin_if.note_code), 16'd5);
      assert_reset();
      chk("mid_rst_zero", 16'(dut_out()), 16'd0);
      repeat (2) cycle();
      rst = 1'b1;
      for (int e = 0; e <= D + 1; e++) begin
         cycle();
         chk("mid_code_wait", 16'(kin_if.note_code), 16'd0);
      end
      cycle();
      chk("mid_code1", 16'(kin_if.note_code), 16'd1);
      repeat (5) cycle();
      chk("mid_no_pulse", 16'(kin_if.pick_pulse), 16'd0);

      // pick held through reset release
      kin_if.raw_keys = '0;
      kin_if.raw_pick = 1'b1;
      assert_reset();
      repeat (3) cycle();
      rst = 1'b1;
      pulses = 0;
      pulse_edge = -1;
      for (int e = 0; e < 30; e++) begin
         cycle();
         if (kin_if.pick_pulse) begin
            pulses++;
            pulse_edge = e;
         end
      end
      chk("held_pulses", 16'(pulses), 16'd1);
      chk("held_edge",   16'(pulse_edge), 16'(D + 2));
      chk("held_level",  16'(kin_if.pick_level), 16'd1);
      kin_if.raw_pick = 1'b0;
      repeat (D + 4) cycle();

      // randomized phases against the model
      for (int p = 0; p < 300; p++) begin
         if ($urandom_range(0, 39) == 0) begin
            assert_reset();
            repeat (2) cycle();
            rst = 1'b1;
         end
         kin_if.raw_keys = 7'($urandom) & 7'($urandom);
         kin_if.raw_pick = 1'($urandom);
         repeat ($urandom_range(1, 8)) cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
